pb_soc_uart_tx: RTL

//  UART transmit path for the Picoblaze SOC; consumes the register-file UART TX outputs.

---
 rtl/pb_soc_uart_tx_pkg.sv | 26 ++
 rtl/pb_soc_uart_tx_if.sv | 16 +
 rtl/pb_soc_uart_fifo.sv | 48 ++++
 rtl/pb_soc_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pb_soc_uart_tx_pkg.sv
// Shared UART encodings: FSM states, status/control bit positions and status packing.
package pb_soc_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int BC_EN       = 0;
  localparam int TXC_EN      = 0;
  localparam int TXC_OVF_CLR = 1;
  localparam int TXC_ODD     = 2;

  typedef struct packed {
    logic ovf;
    logic busy;
    logic full;
    logic empty;
  } fifo_flags_t;

  function automatic logic [7:0] pack_fifo_status(input fifo_flags_t f);
    return {4'b0000, f};
  endfunction

endpackage

// File: rtl/pb_soc_uart_tx_if.sv
// Register-file side of the UART TX block: control/data in, status out.
interface pb_soc_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_write;
  logic [7:0] baud_control;
  logic [7:0] baud_count;
  logic [7:0] tx_control;
  logic [7:0] fifo_status;
  logic [7:0] baud_status;
  logic       tx_done;

  modport master (output tx_data, tx_write, baud_control, baud_count, tx_control,
                  input  fifo_status, baud_status, tx_done);
  modport slave  (input  tx_data, tx_write, baud_control, baud_count, tx_control,
                  output fifo_status, baud_status, tx_done);
endinterface

// File: rtl/pb_soc_uart_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; shared by the TX and RX paths.
module pb_soc_uart_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             rd_i,
  output logic [DW-1:0]    rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [FIFO_AW:0] count_o
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wr_en, rd_en;

  // Full is judged on the pre-edge pointers, so a write into a full FIFO drops even if a pop coincides.
  assign full_o  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[FIFO_AW-1:0]];

  assign wr_en  = wr_i && !full_o;
  assign rd_en  = rd_i && !empty_o;
  assign wptr_d = wptr_q + (FIFO_AW+1)'(wr_en);
  assign rptr_d = rptr_q + (FIFO_AW+1)'(rd_en);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[FIFO_AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pb_soc_uart_tx.sv
// UART transmitter: TX FIFO, baud generator and 8N1 serialiser.
// Define PB_UART_TX_PARITY_EN to insert a parity bit (tx_control[2]: 0=even, 1=odd).
module pb_soc_uart_tx
  import pb_soc_uart_tx_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int CLK_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pb_soc_uart_tx_if.slave  rf,
  output logic             txd_o
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             empty, full, pop, baud_en, tx_en, tick, pre_term, div_term;
  logic [7:0]       head;
  logic [FIFO_AW:0] count;
  logic [PW-1:0]    pre_q, pre_d;
  logic [7:0]       div_q, div_d, lim_q, lim_d;
  logic [2:0]       state_q, state_d, idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d, run_q;
  fifo_flags_t      flags;

  assign baud_en = rf.baud_control[BC_EN];
  assign tx_en   = rf.tx_control[TXC_EN];
  assign pop     = (state_q == ST_IDLE) && !empty && tx_en && baud_en;

  pb_soc_uart_fifo #(.FIFO_AW(FIFO_AW), .DW(8)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (rf.tx_write),
    .wdata_i (rf.tx_data),
    .rd_i    (pop),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  assign pre_term = (pre_q == PW'(CLK_DIV - 1));
  assign div_term = (div_q == lim_q);
  assign tick     = baud_en && pre_term && div_term;

  // The divisor limit is latched on reload so a baud_count change never truncates a bit.
  always_comb begin
    pre_d = pre_q;
    div_d = div_q;
    lim_d = lim_q;
    if (!baud_en || pop) begin
      pre_d = '0;
      div_d = '0;
      lim_d = rf.baud_count;
    end else if (pre_term) begin
      pre_d = '0;
      if (div_term) begin
        div_d = '0;
        lim_d = rf.baud_count;
      end else begin
        div_d = div_q + 8'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

`ifdef PB_UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef PB_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: if (pop) begin
        state_d = ST_START;
        shift_d = head;
`ifdef PB_UART_TX_PARITY_EN
        par_d   = ^head;
`endif
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        idx_d   = 3'd0;
      end
      ST_DATA: if (tick) begin
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
`ifdef PB_UART_TX_PARITY_EN
        if (idx_q == 3'd7) state_d = ST_PARITY;
`else
        if (idx_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef PB_UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (rf.tx_control[TXC_OVF_CLR]) ovf_d = 1'b0;
    else if (rf.tx_write && full)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q   <= '0;
      div_q   <= '0;
      lim_q   <= '0;
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
`ifdef PB_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      pre_q   <= pre_d;
      div_q   <= div_d;
      lim_q   <= lim_d;
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      run_q   <= baud_en;
`ifdef PB_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Line level follows the state directly, so an async reset idles the line at once.
  always_comb begin
    case (state_q)
      ST_START: txd_o = 1'b0;
      ST_DATA:  txd_o = shift_q[0];
`ifdef PB_UART_TX_PARITY_EN
      ST_PARITY: txd_o = par_q ^ rf.tx_control[TXC_ODD];
`endif
      default:  txd_o = 1'b1;
    endcase
  end

  assign flags.ovf      = ovf_q;
  assign flags.busy     = (state_q != ST_IDLE);
  assign flags.full     = full;
  assign flags.empty    = empty;
  assign rf.fifo_status = pack_fifo_status(flags);
  assign rf.baud_status = {6'b000000, run_q, tick};
  assign rf.tx_done     = (state_q == ST_STOP) && tick;

  logic unused_bits;
`ifdef PB_UART_TX_PARITY_EN
  assign unused_bits = ^{count, rf.baud_control[7:1], rf.tx_control[7:3]};
`else
  assign unused_bits = ^{count, rf.baud_control[7:1], rf.tx_control[7:2]};
`endif

endmodule
